// File: rtl/sort_seq_pkg.sv
// Shared types and constants for the sequential sort controller.
package sort_seq_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_e;

    localparam int unsigned VAL_W    = 4;
    localparam int unsigned SWAP_MAX = 255;

endpackage

// File: rtl/signed_cmp4.sv
// Combinational two's-complement comparator for 4-bit operands; exactly one of gt/eq/lt is high.
module signed_cmp4
    import sort_seq_pkg::*;
(
    input  logic [VAL_W-1:0] a,
    input  logic [VAL_W-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    logic a_neg;
    logic b_neg;

    assign a_neg = a[VAL_W-1];
    assign b_neg = b[VAL_W-1];

    always_comb begin
        eq = (a == b);
        // Mixed signs: the non-negative operand is larger; same sign orders by bit pattern.
        if (a_neg != b_neg) begin
            gt = b_neg;
        end else begin
            gt = (a > b);
        end
        lt = !gt && !eq;
    end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Loads a burst of DEPTH signed values, bubble-sorts them in place through one shared
// comparator (one compare-and-swap per cycle), then streams them out in ascending order.
module sort_seq_ctrl
    import sort_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_valid,
    input  logic [VAL_W-1:0] In_data,
    output logic             In_ready,
    output logic             Out_valid,
    output logic [VAL_W-1:0] Out_data,
    output logic             Out_last,
    input  logic             Out_ready,
    output logic             Busy,
    output logic [7:0]       Swap_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_e state_q, state_d;

    logic [VAL_W-1:0] buf_q [DEPTH];
    logic [VAL_W-1:0] buf_d [DEPTH];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] lim_q, lim_d;
    logic             swapped_q, swapped_d;
    logic [7:0]       swap_cnt_q, swap_cnt_d;

    logic [IDX_W-1:0] j_nxt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic             swapped_now;
    logic             pass_end;
    logic             sort_done;

    assign j_nxt       = j_q + ONE_IDX;
    assign swapped_now = swapped_q | cmp_gt;
    assign pass_end    = (j_nxt >= lim_q);
    assign sort_done   = pass_end && (!swapped_now || (lim_q == ONE_IDX));

    signed_cmp4 u_cmp (
        .a  (buf_q[j_q]),
        .b  (buf_q[j_nxt]),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    always_comb begin
        assert ($onehot({cmp_gt, cmp_eq, cmp_lt}));
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (In_valid && (wr_idx_q == LAST_IDX)) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                if (sort_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (Out_ready && (rd_idx_q == LAST_IDX)) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Datapath next-state
    always_comb begin
        buf_d      = buf_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        j_d        = j_q;
        lim_d      = lim_q;
        swapped_d  = swapped_q;
        swap_cnt_d = swap_cnt_q;
        unique case (state_q)
            LOAD: begin
                if (In_valid) begin
                    buf_d[wr_idx_q] = In_data;
                    wr_idx_d        = wr_idx_q + ONE_IDX;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d   = '0;
                        j_d        = '0;
                        lim_d      = LAST_IDX;
                        swapped_d  = 1'b0;
                        swap_cnt_d = '0;
                    end
                end
            end
            SORT: begin
                if (cmp_gt) begin
                    buf_d[j_q]   = buf_q[j_nxt];
                    buf_d[j_nxt] = buf_q[j_q];
                    if (swap_cnt_q != 8'(SWAP_MAX)) begin
                        swap_cnt_d = swap_cnt_q + 8'd1;
                    end
                end
                swapped_d = swapped_now;
                if (!pass_end) begin
                    j_d = j_nxt;
                end else if (sort_done) begin
                    rd_idx_d = '0;
                end else begin
                    lim_d     = lim_q - ONE_IDX;
                    j_d       = '0;
                    swapped_d = 1'b0;
                end
            end
            DRAIN: begin
                if (Out_ready) begin
                    rd_idx_d = rd_idx_q + ONE_IDX;
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            j_q        <= '0;
            lim_q      <= '0;
            swapped_q  <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            j_q        <= j_d;
            lim_q      <= lim_d;
            swapped_q  <= swapped_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch.
    always_ff @(posedge Clk) begin
        buf_q <= buf_d;
    end

    // Outputs
    always_comb begin
        In_ready  = (state_q == LOAD);
        Busy      = (state_q == SORT);
        Out_valid = (state_q == DRAIN);
        Out_data  = (state_q == DRAIN) ? buf_q[rd_idx_q] : '0;
        Out_last  = (state_q == DRAIN) && (rd_idx_q == LAST_IDX);
        Swap_cnt  = swap_cnt_q;
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Bench for sort_seq_ctrl: directed vector table, hand-written reset/ignore sequences and
// random bursts, with a scoreboard queue of expected output values.
module tb_sort_seq_ctrl;

    localparam int DEPTH = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       In_valid = 1'b0;
    logic [3:0] In_data = '0;
    logic       Out_ready = 1'b0;
    logic       In_ready;
    logic       Out_valid;
    logic [3:0] Out_data;
    logic       Out_last;
    logic       Busy;
    logic [7:0] Swap_cnt;

    sort_seq_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_valid  (In_valid),
        .In_data   (In_data),
        .In_ready  (In_ready),
        .Out_valid (Out_valid),
        .Out_data  (Out_data),
        .Out_last  (Out_last),
        .Out_ready (Out_ready),
        .Busy      (Busy),
        .Swap_cnt  (Swap_cnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int sb[$];

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        int          sort_cyc;
        int          swaps;
        int          mode;
        bit          hold;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [15:0] p4(int a, int b, int c, int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic int el(logic [15:0] v, int i);
        logic signed [3:0] t;
        t = v[4*i +: 4];
        return int'(t);
    endfunction

    function automatic int sval(logic [3:0] v);
        logic signed [3:0] t;
        t = v;
        return int'(t);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(logic [15:0] din);
        for (int i = 0; i < DEPTH; i++) begin
            int b = 0;
            while (!In_ready && b < 100) begin
                @(negedge Clk);
                b++;
            end
            if (!In_ready) chk("load_ready_timeout", 0, 1);
            In_valid = 1'b1;
            In_data  = 4'(el(din, i));
            @(negedge Clk);
        end
        In_valid = 1'b0;
    endtask

    task automatic sort_phase(int exp_cyc, int exp_sw);
        int c = 0;
        chk("busy_start", int'(Busy), 1);
        while (Busy && c < 100) begin
            if (In_valid) chk("in_ready_sort", int'(In_ready), 0);
            c++;
            @(negedge Clk);
        end
        chk("sort_cycles", c, exp_cyc);
        chk("swap_cnt", int'(Swap_cnt), exp_sw);
        chk("out_valid_rise", int'(Out_valid), 1);
    endtask

    // mode 0: always ready, 1: 5 stall cycles then toggle, 2: random ready
    task automatic drain(int mode);
        int cyc = 0;
        int expd;
        logic rdy;
        while (sb.size() > 0 && cyc < 200) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc >= 5) && ((cyc - 5) % 2 == 0);
            else rdy = 1'($urandom_range(0, 1));
            Out_ready = rdy;
            chk("out_valid", int'(Out_valid), 1);
            if (In_valid) chk("in_ready_drain", int'(In_ready), 0);
            expd = sb[0];
            chk("out_data", sval(Out_data), expd);
            if (rdy) begin
                void'(sb.pop_front());
                chk("out_last", int'(Out_last), int'(sb.size() == 0));
            end
            @(negedge Clk);
            cyc++;
        end
        Out_ready = 1'b0;
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        if (mode == 0) chk("drain_cycles", cyc, DEPTH);
        chk("in_ready_after", int'(In_ready), 1);
        chk("out_valid_after", int'(Out_valid), 0);
    endtask

    task automatic run_burst(vec_t v);
        for (int i = 0; i < DEPTH; i++) sb.push_back(el(v.dout, i));
        load(v.din);
        if (v.hold) begin
            In_valid = 1'b1;
            In_data  = 4'd4;
        end
        sort_phase(v.sort_cyc, v.swaps);
        drain(v.mode);
        In_valid = 1'b0;
        chk("swap_cnt_hold", int'(Swap_cnt), v.swaps);
    endtask

    task automatic random_burst();
        vec_t v;
        int a[DEPTH];
        int lim, t, cyc, sw;
        bit swp;
        for (int i = 0; i < DEPTH; i++) a[i] = sval(4'($urandom_range(0, 15)));
        v.din = p4(a[0], a[1], a[2], a[3]);
        cyc = 0;
        sw  = 0;
        lim = DEPTH - 1;
        forever begin
            swp = 1'b0;
            for (int j = 0; j < lim; j++) begin
                cyc++;
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    swp = 1'b1;
                    sw++;
                end
            end
            if (!swp || lim == 1) break;
            lim--;
        end
        v.dout     = p4(a[0], a[1], a[2], a[3]);
        v.sort_cyc = cyc;
        v.swaps    = sw;
        v.mode     = 2;
        v.hold     = 1'b0;
        run_burst(v);
    endtask

    initial begin
        tbl[0] = '{p4(-8, -5, 2, 7), p4(-8, -5, 2, 7), 3, 0, 0, 1'b0};
        tbl[1] = '{p4(7, 2, -1, -8), p4(-8, -1, 2, 7), 6, 6, 0, 1'b0};
        tbl[2] = '{p4(5, -1, 5, 0),  p4(-1, 0, 5, 5),  6, 3, 0, 1'b0};
        tbl[3] = '{p4(3, -2, 1, -8), p4(-8, -2, 1, 3), 6, 5, 1, 1'b0};
        tbl[4] = '{p4(1, 0, -3, 6),  p4(-3, 0, 1, 6),  6, 3, 0, 1'b1};

        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst_in_ready", int'(In_ready), 1);
        chk("rst_out_valid", int'(Out_valid), 0);
        chk("rst_out_last", int'(Out_last), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_out_data", int'(Out_data), 0);
        chk("rst_swap_cnt", int'(Swap_cnt), 0);

        for (int k = 0; k < 5; k++) run_burst(tbl[k]);

        // Reset in the second SORT cycle discards the burst.
        load(p4(7, 2, -1, -8));
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midsort_in_ready", int'(In_ready), 1);
        chk("midsort_busy", int'(Busy), 0);
        chk("midsort_swap_cnt", int'(Swap_cnt), 0);
        chk("midsort_out_valid", int'(Out_valid), 0);
        run_burst('{p4(0, 1, 2, 3), p4(0, 1, 2, 3), 3, 0, 0, 1'b0});

        for (int k = 0; k < 12; k++) random_burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_seq_ctrl.md
# sort_seq_ctrl

Sequential sort controller that time-shares one combinational signed 4-bit comparator to sort a small buffer of two's-complement values into ascending order. It accepts a burst of DEPTH values over a valid/ready input stream and sorts them in place with early-terminating bubble-sort passes, one compare-and-swap per cycle. It then streams the sorted values out over a valid/ready output stream. It sits between a value producer and any consumer that needs ordered data, and is the scheduler for the lab's signed-compare datapath.

## Interface
- DEPTH, 4, number of values per burst; legal range 2..16.
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_valid  input  1  producer has a value on In_data.
- In_data  input  4  two's-complement value, range -8..7.
- In_ready  output  1  block accepts a value this cycle.
- Out_valid  output  1  Out_data holds a sorted value.
- Out_data  output  4  sorted value; smallest value comes out first.
- Out_last  output  1  high with the final (DEPTH-th) output value.
- Out_ready  input  1  consumer accepts the output this cycle.
- Busy  output  1  high while in the SORT state.
- Swap_cnt  output  8  number of swaps in the last completed sort; saturates at 255.

## Operation
- The design has one clock and a synchronous active-high reset, using ports Clk and Reset as listed above.
- Storage is a register array buf[0..DEPTH-1] of 4 bits per entry. Indices are wr_idx, rd_idx and j, each $clog2(DEPTH) bits wide. lim is the pass limit. swapped is a 1-bit flag.
- The state machine has three states: LOAD, SORT and DRAIN.
- LOAD:
  - In_ready is 1.
  - When In_valid and In_ready are both high, buf[wr_idx] gets In_data and wr_idx increments.
  - When the accepted value is entry DEPTH-1, go to SORT with j=0, lim=DEPTH-1, swapped=0, and Swap_cnt cleared.
- SORT:
  - Busy is 1.
  - Each cycle the comparator receives buf[j] and buf[j+1].
  - The comparator is signed: a negative value is less than a non-negative value, and same-sign values compare by bit pattern.
  - If buf[j] > buf[j+1], swap the two entries, set swapped, and increment Swap_cnt (saturating).
  - Equal entries are never swapped, so the sort is stable.
  - If j+1 < lim, increment j.
  - Otherwise the pass ends:
    - If swapped is 0 or lim equals 1, go to DRAIN with rd_idx=0.
    - Otherwise decrement lim, set j=0, clear swapped, and start the next pass.
  - The swapped flag used in the end-of-pass decision includes any swap made in the final compare of the pass.
- DRAIN:
  - Out_valid is 1 and Out_data = buf[rd_idx].
  - Out_last = (rd_idx == DEPTH-1).
  - When Out_ready is high, rd_idx increments.
  - A transfer with Out_last high returns to LOAD with wr_idx=0.
- In_ready is 0 outside LOAD, so In_valid is ignored in SORT and DRAIN.
- Swap_cnt holds its value until the next entry into SORT.

## Timing
- Values after reset (the cycle after Reset is sampled high):
  - State is LOAD and In_ready is 1.
  - Out_valid, Out_last and Busy are 0.
  - Out_data is 0 and Swap_cnt is 0.
  - All indices are 0.
  - buf contents are don't-care.
- Reset takes priority over every state. A reset in the middle of LOAD, SORT or DRAIN discards the burst.
- All outputs are driven from registered state; there is no combinational path from inputs to outputs.
- Input transfer: the value is written at the clock edge where In_valid and In_ready are both high. SORT begins the cycle after the DEPTH-th transfer.
- SORT lasts from DEPTH-1 cycles (input already sorted) up to DEPTH*(DEPTH-1)/2 cycles (input in reverse order).
- Out_valid rises the cycle after the final compare.
- Output transfer happens on any cycle with Out_valid and Out_ready both high.
  - Out_data and Out_last stay stable while Out_ready is low.
  - A full drain takes DEPTH cycles when Out_ready is held high.
- After the last transfer, In_ready rises on the next cycle. There is no overlap between the drain of one burst and the load of the next.

## Structure
- Package sort_seq_pkg contains:
  - the state enum {LOAD, SORT, DRAIN};
  - localparam VAL_W = 4;
  - localparam SWAP_MAX = 255.
- One sub-module, signed_cmp4: a purely combinational comparator with inputs a[3:0] and b[3:0] and outputs gt, eq and lt, exactly one of which is high.
  - It derives the sign of each operand from bit 3.
  - The controller instantiates it once and uses only its gt output to decide swaps.

## Test plan
- Already-sorted input, DEPTH=4, In_data = -8, -5, 2, 7 → SORT lasts 3 cycles, Swap_cnt=0, output -8, -5, 2, 7 with Out_last on 7.
- Reverse-order input, 7, 2, -1, -8 → SORT lasts 6 cycles, Swap_cnt=6, output -8, -1, 2, 7.
- Equal values and the sign boundary, 5, -1, 5, 0 → output -1, 0, 5, 5. Swap_cnt=3, and the two 5s are never swapped with each other.
- Backpressure: load 3, -2, 1, -8, then hold Out_ready low for 5 cycles, then toggle it high and low each cycle → Out_data stays at -8 while stalled; the outputs are -8, -2, 1, 3, each presented exactly once.
- Reset mid-SORT: load 7, 2, -1, -8 and assert Reset in the 2nd SORT cycle → next cycle In_ready=1, Busy=0, Swap_cnt=0. A fresh burst 0, 1, 2, 3 then outputs 0, 1, 2, 3.
- Input ignored outside LOAD: hold In_valid=1 with In_data=4 throughout SORT and DRAIN → In_ready stays 0 and the output data is unchanged.
